nios2_qsys_oci_dct_packer: RTL and testbench
============================================

Name: nios2_qsys_oci_dct_packer

Overview:
- Packs direct-control-transfer (DCT) branch outcome codes from the Nios II debug trace path into 30-bit frames for the on-chip trace FIFO.
- Drives the live `dct_buffer` and `dct_count` signals consumed by the OCI test bench.
- Sits directly upstream of that test bench and of the trace frame writer.
- Issues one frame per 15 codes, or a short frame on flush or trace-off.

Parameters:
- `CODE_W`, 2: width of one DCT code.
- `SLOTS`, 15: codes per full frame; must satisfy `SLOTS <= 15` and `CODE_W*SLOTS = 30`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `trc_on`  in  1  trace enable; high = capture codes.
- `dct_valid`  in  1  one code presented this cycle.
- `dct_code`  in  2  code: 00 not-taken, 01 taken, 10/11 passed through unchanged.
- `flush`  in  1  force emission of a partial frame.
- `clear_overflow`  in  1  clears sticky overflow.
- `frame_ready`  in  1  downstream accepts frame.
- `frame_valid`  out  1  frame register holds a frame.
- `frame_data`  out  30  packed frame; oldest code in the highest occupied slot.
- `frame_count`  out  4  number of valid codes in the frame (1..15).
- `dct_buffer`  out  30  live accumulation buffer.
- `dct_count`  out  4  codes currently in the live buffer (0..15).
- `overflow`  out  1  sticky; set when a frame is lost.

Behaviour:
- Reset: asynchronous, active-high. While `reset` is high, all of the following are zero: `dct_buffer`, `dct_count`, `frame_valid`, `frame_data`, `frame_count`, `overflow`, and the internal `trc_on_d`.
- Accept:
  - A code is accepted when `dct_valid && trc_on`.
  - `buf_next = {dct_buffer[27:0], dct_code}` and `cnt_next = dct_count + 1`.
  - The new code always enters at bits [1:0]; older codes shift toward the MSB.
- Emit conditions, evaluated on post-accept values:
  - (a) `cnt_next == 15`;
  - (b) `flush && cnt_next != 0`;
  - (c) trc_on falling edge (`trc_on_d && !trc_on`) with `dct_count != 0`.
  - Flush or trace-off with an empty buffer emits nothing.
- Frame register free: `!frame_valid || frame_ready`, using the current-cycle `frame_ready`.
- On emit with frame register free:
  - `frame_data <= buf_next`, `frame_count <= cnt_next`, `frame_valid <= 1`.
  - `dct_buffer <= 0`, `dct_count <= 0`.
  - Emission latency: 1 clock after the triggering edge.
- On emit with frame register busy:
  - The emitting frame is discarded.
  - Live buffer is cleared to 0 / 0.
  - `overflow <= 1`.
  - The held frame is untouched.
- Without emit: if `frame_valid && frame_ready`, then `frame_valid <= 0`; `frame_data` and `frame_count` hold their last value.
- Frame hold: `frame_data` and `frame_count` are stable while `frame_valid && !frame_ready`.
- Simultaneous cases:
  - Code plus flush in the same cycle: the code is included in the flushed frame.
  - Downstream accepts and a new emit occurs in the same cycle: back-to-back frame, no bubble; `frame_valid` stays 1.
- Overflow register:
  - `clear_overflow` has priority below a new overflow event in the same cycle, so `overflow` stays 1.
  - Otherwise `clear_overflow` clears it.
- Codes are ignored while `trc_on` is low, and `dct_count` does not change.
- `dct_count` never exceeds 15; wrap to 0 occurs only through emit.
- Reset mid-frame: the pending frame and the live buffer are lost, with no overflow indication.

Test Plan:
- Reset, then 15 codes alternating 01,00 with `frame_ready` = 1 → one cycle after the 15th code: `frame_valid` = 1, `frame_count` = 15, `frame_data` = 30'h11111111 (pattern 01 00 ... 01 from MSB pair); `dct_count` = 0.
- 3 codes 01,01,00, then `flush` in the next cycle → `frame_count` = 3, `frame_data` = 30'h14; `dct_buffer` = 0.
- Code 11 and `flush` in the same cycle, with buffer already holding 1 code 01 → `frame_count` = 2, `frame_data` = 30'h7.
- Hold `frame_ready` = 0 while 30 codes arrive →
  - first frame held stable;
  - second emit raises `overflow`;
  - `dct_count` = 0 after code 30;
  - `clear_overflow` then drops `overflow`.
- `trc_on` falls with `dct_count` = 5 → one frame with `frame_count` = 5; further `dct_valid` pulses leave `dct_count` = 0.
- Assert `reset` while `frame_valid` = 1 and `dct_count` = 7 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/nios2_qsys_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// nios2_qsys_oci_dct_packer
//
// Packs 2-bit direct-control-transfer (DCT) branch outcome codes into 30-bit
// trace frames. Codes shift in at the LSBs. The oldest code therefore ends up
// in the highest occupied slot. A frame is issued when the buffer fills
// (15 codes), on flush, or when tracing is switched off with codes pending.
// A single frame register feeds downstream. Its valid/ready handshake works
// as follows:
//   - a frame transfers on any cycle where frame_valid && frame_ready;
//   - frame_data/frame_count stay stable while frame_valid && !frame_ready;
//   - an emit that finds the register busy is dropped and sets overflow.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   trc_on         in   trace enable (codes captured only while high)
//   dct_valid      in   a code is presented this cycle
//   dct_code       in   the code (00 not-taken, 01 taken, 10/11 passthrough)
//   flush          in   force emission of a partial frame
//   clear_overflow in   clears the sticky overflow flag
//   frame_ready    in   downstream accepts the held frame
//   frame_valid    out  frame register holds a frame
//   frame_data     out  packed frame
//   frame_count    out  valid codes in the frame (1..15)
//   dct_buffer     out  live accumulation buffer
//   dct_count      out  codes in the live buffer (0..15)
//   overflow       out  sticky frame-lost indication
// ---------------------------------------------------------------------------
module nios2_qsys_oci_dct_packer #(
    parameter int CODE_W = 2,
    parameter int SLOTS  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trc_on,
    input  logic                      dct_valid,
    input  logic [CODE_W-1:0]         dct_code,
    input  logic                      flush,
    input  logic                      clear_overflow,
    input  logic                      frame_ready,
    output logic                      frame_valid,
    output logic [CODE_W*SLOTS-1:0]   frame_data,
    output logic [3:0]                frame_count,
    output logic [CODE_W*SLOTS-1:0]   dct_buffer,
    output logic [3:0]                dct_count,
    output logic                      overflow
);

    localparam int FRAME_W = CODE_W * SLOTS;

    logic [FRAME_W-1:0] r_dct_buffer;
    logic [3:0]         r_dct_count;
    logic               r_frame_valid;
    logic [FRAME_W-1:0] r_frame_data;
    logic [3:0]         r_frame_count;
    logic               r_overflow;
    logic               r_trc_on_d;

    logic               w_accept;
    logic [FRAME_W-1:0] w_buf_next;
    logic [3:0]         w_cnt_next;
    logic               w_trc_fall;
    logic               w_emit;
    logic               w_frame_free;

    assign w_accept   = dct_valid && trc_on;
    assign w_buf_next = w_accept ? {r_dct_buffer[FRAME_W-CODE_W-1:0], dct_code}
                                 : r_dct_buffer;
    assign w_cnt_next = w_accept ? r_dct_count + 4'd1 : r_dct_count;
    assign w_trc_fall = r_trc_on_d && !trc_on;

    // The trace-off term uses the pre-accept count. No code can be accepted
    // while trc_on is low, so this is the same as the post-accept count.
    assign w_emit = (w_cnt_next == 4'(SLOTS))
                 || (flush && (w_cnt_next != 4'd0))
                 || (w_trc_fall && (r_dct_count != 4'd0));

    // Same-cycle frame_ready frees the register, which allows back-to-back frames.
    assign w_frame_free = !r_frame_valid || frame_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dct_buffer  <= '0;
            r_dct_count   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_trc_on_d    <= 1'b0;
        end else begin
            r_trc_on_d <= trc_on;

            if (w_emit) begin
                // The live buffer restarts even when the frame is lost.
                r_dct_buffer <= '0;
                r_dct_count  <= '0;
                if (w_frame_free) begin
                    r_frame_data  <= w_buf_next;
                    r_frame_count <= w_cnt_next;
                    r_frame_valid <= 1'b1;
                end
            end else begin
                r_dct_buffer <= w_buf_next;
                r_dct_count  <= w_cnt_next;
                if (r_frame_valid && frame_ready) begin
                    r_frame_valid <= 1'b0;
                end
            end

            // A new loss event wins over a same-cycle clear.
            if (w_emit && !w_frame_free) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_data  = r_frame_data;
    assign frame_count = r_frame_count;
    assign dct_buffer  = r_dct_buffer;
    assign dct_count   = r_dct_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_nios2_qsys_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_nios2_qsys_oci_dct_packer
//
// Directed bench for the DCT packer. Each scenario task drives its own
// stimulus and compares outputs against hand-computed values. Inputs change
// 1 ns after the rising edge. Outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_nios2_qsys_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        trc_on;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        clear_overflow;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] frame_data;
    logic [3:0]  frame_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    nios2_qsys_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .trc_on         (trc_on),
        .dct_valid      (dct_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .frame_ready    (frame_ready),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .frame_count    (frame_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [1:0] c);
        dct_valid = 1'b1;
        dct_code  = c;
        step();
        dct_valid = 1'b0;
        dct_code  = 2'b00;
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++;
        if ({frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got fv=%0b fd=%h fc=%0d buf=%h cnt=%0d ovf=%0b exp all 0",
                     frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_full_frame();
        frame_ready = 1'b1;
        for (int i = 0; i < 14; i++) send_code((i % 2 == 0) ? 2'b01 : 2'b00);
        checks++;
        if (dct_count !== 4'd14 || dct_buffer !== 30'h04444444 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_partial got cnt=%0d buf=%h fv=%0b exp cnt=14 buf=04444444 fv=0",
                     dct_count, dct_buffer, frame_valid);
        end
        send_code(2'b01);
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd15 || frame_data !== 30'h11111111
            || dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
            failures++;
            $display("FAIL full_frame got fv=%0b fc=%0d fd=%h cnt=%0d buf=%h exp 1/15/11111111/0/0",
                     frame_valid, frame_count, frame_data, dct_count, dct_buffer);
        end
        step();
        checks++;
        if (frame_valid !== 1'b0 || frame_data !== 30'h11111111 || frame_count !== 4'd15) begin
            failures++;
            $display("FAIL full_drain got fv=%0b fd=%h fc=%0d exp fv=0 fd=11111111 fc=15",
                     frame_valid, frame_data, frame_count);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got fv=%0b ovf=%0b exp fv=0 ovf=0", frame_valid, overflow);
        end
        send_code(2'b01);
        send_code(2'b01);
        send_code(2'b00);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd3 || frame_data !== 30'h14
            || dct_buffer !== 30'h0 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_frame got fv=%0b fc=%0d fd=%h buf=%h cnt=%0d exp 1/3/14/0/0",
                     frame_valid, frame_count, frame_data, dct_buffer, dct_count);
        end
        step();
    endtask

    task automatic test_code_with_flush();
        send_code(2'b01);
        flush = 1'b1;
        send_code(2'b11);
        flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd2 || frame_data !== 30'h7 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL code_flush got fv=%0b fc=%0d fd=%h cnt=%0d exp 1/2/7/0",
                     frame_valid, frame_count, frame_data, dct_count);
        end
        step();
    endtask

    task automatic test_overflow();
        frame_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_code((i % 2 == 0) ? 2'b01 : 2'b00);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h11111111 || frame_count !== 4'd15 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first got fv=%0b fd=%h fc=%0d ovf=%0b exp 1/11111111/15/0",
                     frame_valid, frame_data, frame_count, overflow);
        end
        for (int i = 0; i < 14; i++) begin
            send_code(2'b10);
            checks++;
            if (frame_data !== 30'h11111111 || frame_count !== 4'd15 || overflow !== 1'b0
                || dct_count !== 4'(i + 1)) begin
                failures++;
                $display("FAIL ovf_hold[%0d] got fd=%h fc=%0d ovf=%0b cnt=%0d exp 11111111/15/0/%0d",
                         i, frame_data, frame_count, overflow, dct_count, i + 1);
            end
        end
        send_code(2'b10);
        checks++;
        if (overflow !== 1'b1 || dct_count !== 4'd0 || dct_buffer !== 30'h0
            || frame_valid !== 1'b1 || frame_data !== 30'h11111111) begin
            failures++;
            $display("FAIL ovf_set got ovf=%0b cnt=%0d buf=%h fv=%0b fd=%h exp 1/0/0/1/11111111",
                     overflow, dct_count, dct_buffer, frame_valid, frame_data);
        end
        // A new loss in the same cycle as clear keeps the flag set.
        for (int i = 0; i < 14; i++) send_code(2'b00);
        clear_overflow = 1'b1;
        send_code(2'b01);
        checks++;
        if (overflow !== 1'b1 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL ovf_priority got ovf=%0b cnt=%0d exp ovf=1 cnt=0", overflow, dct_count);
        end
        step();
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0 || frame_data !== 30'h11111111) begin
            failures++;
            $display("FAIL ovf_clear got ovf=%0b fd=%h exp ovf=0 fd=11111111", overflow, frame_data);
        end
        frame_ready = 1'b1;
        step();
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain got fv=%0b exp 0", frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        frame_ready = 1'b1;
        flush = 1'b1;
        send_code(2'b01);
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h1 || frame_count !== 4'd1) begin
            failures++;
            $display("FAIL b2b_first got fv=%0b fd=%h fc=%0d exp 1/1/1", frame_valid, frame_data, frame_count);
        end
        send_code(2'b10);
        flush = 1'b0;
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 30'h2 || frame_count !== 4'd1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second got fv=%0b fd=%h fc=%0d ovf=%0b exp 1/2/1/0",
                     frame_valid, frame_data, frame_count, overflow);
        end
        step();
    endtask

    task automatic test_trc_off();
        frame_ready = 1'b1;
        send_code(2'b01);
        send_code(2'b00);
        send_code(2'b01);
        send_code(2'b01);
        send_code(2'b10);
        checks++;
        if (dct_count !== 4'd5 || dct_buffer !== 30'h116 || frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL trc_pre got cnt=%0d buf=%h fv=%0b exp 5/116/0", dct_count, dct_buffer, frame_valid);
        end
        trc_on = 1'b0;
        step();
        checks++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd5 || frame_data !== 30'h116 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL trc_off_frame got fv=%0b fc=%0d fd=%h cnt=%0d exp 1/5/116/0",
                     frame_valid, frame_count, frame_data, dct_count);
        end
        for (int i = 0; i < 3; i++) begin
            send_code(2'b01);
            checks++;
            if (dct_count !== 4'd0 || dct_buffer !== 30'h0 || frame_valid !== 1'b0) begin
                failures++;
                $display("FAIL trc_ignore[%0d] got cnt=%0d buf=%h fv=%0b exp 0/0/0",
                         i, dct_count, dct_buffer, frame_valid);
            end
        end
        trc_on = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        frame_ready = 1'b0;
        flush = 1'b1;
        send_code(2'b01);
        flush = 1'b0;
        for (int i = 0; i < 7; i++) send_code(2'b11);
        checks++;
        if (frame_valid !== 1'b1 || dct_count !== 4'd7) begin
            failures++;
            $display("FAIL rst_mid_pre got fv=%0b cnt=%0d exp fv=1 cnt=7", frame_valid, dct_count);
        end
        // Assert reset between clock edges; outputs must clear without an edge.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow} !== '0) begin
            failures++;
            $display("FAIL rst_async got fv=%0b fd=%h fc=%0d buf=%h cnt=%0d ovf=%0b exp all 0",
                     frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        frame_ready = 1'b1;
        step();
        checks++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_after got fv=%0b cnt=%0d ovf=%0b exp 0/0/0", frame_valid, dct_count, overflow);
        end
    endtask

    // Sequence and final report
    initial begin
        reset          = 1'b1;
        trc_on         = 1'b1;
        dct_valid      = 1'b0;
        dct_code       = 2'b00;
        flush          = 1'b0;
        clear_overflow = 1'b0;
        frame_ready    = 1'b1;

        test_reset();
        test_full_frame();
        test_flush();
        test_code_with_flush();
        test_overflow();
        test_back_to_back();
        test_trc_off();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
